// File: rtl/alu_pipe.sv
// Registered, valid/ready handshaked ALU with NZCV flags for the pipelined LEGv8 datapath.
// Define ALU_MUL_EN to add the iterative shift-add multiplier on opcode 1010.
module alu_pipe #(
  parameter int N  = 64,
  parameter int SW = $clog2(N)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [N-1:0] BusA,
  input  logic [N-1:0] BusB,
  input  logic [3:0]   ALUCtrl,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [N-1:0] BusW,
  output logic         Zero,
  output logic         Negative,
  output logic         Carry,
  output logic         Overflow
);

  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOr    = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpLsl   = 4'b0011;
  localparam logic [3:0] OpLsr   = 4'b0100;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpPassB = 4'b0111;
  localparam logic [3:0] OpXor   = 4'b1000;
  localparam logic [3:0] OpAsr   = 4'b1001;

`ifdef ALU_MUL_EN
  localparam logic [3:0]    OpMul    = 4'b1010;
  localparam logic [SW-1:0] LastStep = SW'(N - 1);
  typedef enum logic {IDLE, MULT} stateT;
`else
  typedef enum logic {IDLE} stateT;
`endif

  stateT state, nextState;

  logic          accept;
  logic [SW-1:0] shamt;
  logic [N:0]    sum, diff;
  logic [N-1:0]  aluResult;
  logic          aluCarry, aluOverflow;

  assign shamt    = BusB[SW-1:0];
  assign InReady  = (state == IDLE) && (!OutValid || OutReady);
  assign accept   = InValid && InReady;
  assign Zero     = (BusW == '0);
  assign Negative = BusW[N-1];

`ifdef ALU_MUL_EN
  logic          isMul;
  logic [N-1:0]  mcand, mplier, acc, accNext;
  logic [SW-1:0] count;

  assign isMul   = (ALUCtrl == OpMul);
  assign accNext = acc + (mplier[0] ? mcand : '0);
`endif

  // Single-cycle operations; SUB carry is the ARM no-borrow convention.
  always_comb begin
    sum         = {1'b0, BusA} + {1'b0, BusB};
    diff        = {1'b0, BusA} - {1'b0, BusB};
    aluResult   = '0;
    aluCarry    = 1'b0;
    aluOverflow = 1'b0;
    case (ALUCtrl)
      OpAnd:   aluResult = BusA & BusB;
      OpOr:    aluResult = BusA | BusB;
      OpXor:   aluResult = BusA ^ BusB;
      OpPassB: aluResult = BusB;
      OpLsl:   aluResult = BusA << shamt;
      OpLsr:   aluResult = BusA >> shamt;
      OpAsr:   aluResult = $signed(BusA) >>> shamt;
      OpAdd: begin
        aluResult   = sum[N-1:0];
        aluCarry    = sum[N];
        aluOverflow = (BusA[N-1] == BusB[N-1]) && (sum[N-1] != BusA[N-1]);
      end
      OpSub: begin
        aluResult   = diff[N-1:0];
        aluCarry    = ~diff[N];
        aluOverflow = (BusA[N-1] != BusB[N-1]) && (diff[N-1] != BusA[N-1]);
      end
      default: aluResult = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = IDLE;
`ifdef ALU_MUL_EN
    case (state)
      IDLE:    if (accept && isMul) nextState = MULT;
      MULT:    if (count != LastStep) nextState = MULT;
      default: nextState = IDLE;
    endcase
`endif
  end

  // Output register; an accept may coincide with the drain of the previous result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      OutValid <= 1'b0;
      BusW     <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
`ifdef ALU_MUL_EN
      count    <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
`endif
    end else if (accept) begin
`ifdef ALU_MUL_EN
      if (isMul) begin
        OutValid <= 1'b0;
        mcand    <= BusA;
        mplier   <= BusB;
        acc      <= '0;
        count    <= '0;
      end else begin
        OutValid <= 1'b1;
        BusW     <= aluResult;
        Carry    <= aluCarry;
        Overflow <= aluOverflow;
      end
`else
      OutValid <= 1'b1;
      BusW     <= aluResult;
      Carry    <= aluCarry;
      Overflow <= aluOverflow;
`endif
`ifdef ALU_MUL_EN
    end else if (state == MULT) begin
      // One multiplier bit per cycle; the final step publishes the low N product bits.
      if (count == LastStep) begin
        BusW     <= accNext;
        Carry    <= 1'b0;
        Overflow <= 1'b0;
        OutValid <= 1'b1;
        count    <= '0;
      end else begin
        count    <= count + SW'(1);
      end
      acc    <= accNext;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
`endif
    end else if (OutValid && OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (N=64): directed vector table, stall/reset sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_alu_pipe;

  localparam int N = 64;

  logic         Clk = 1'b0;
  logic         Reset, InValid, InReady, OutValid, OutReady;
  logic         Zero, Negative, Carry, Overflow;
  logic [N-1:0] BusA, BusB, BusW;
  logic [3:0]   ALUCtrl;

  int checks = 0;
  int passed = 0;

  always #5 Clk = ~Clk;

  alu_pipe #(.N(N)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .OutValid(OutValid),
    .OutReady(OutReady), .BusW(BusW), .Zero(Zero), .Negative(Negative),
    .Carry(Carry), .Overflow(Overflow)
  );

  typedef struct {
    logic [63:0] w;
    logic [3:0]  zncv;
  } resT;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [63:0] a, b;
    logic [63:0] expW;
    logic [3:0]  expZncv;
  } vecT;

  // Reference behaviour straight from the opcode definitions.
  function automatic resT model(logic [3:0] op, logic [63:0] a, logic [63:0] b);
    resT r;
    int sh = int'(b[5:0]);
    logic signed [64:0] sa = $signed(a);
    logic signed [64:0] sb = $signed(b);
    logic signed [64:0] s;
    logic c = 1'b0, v = 1'b0;
    logic [64:0] wide;
    case (op)
      4'b0000: r.w = a & b;
      4'b0001: r.w = a | b;
      4'b0010: begin
        wide = {1'b0, a} + {1'b0, b};
        r.w = wide[63:0];
        c = wide[64];
        s = sa + sb;
        v = (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -65'sh0_8000_0000_0000_0000);
      end
      4'b0011: r.w = a << sh;
      4'b0100: r.w = a >> sh;
      4'b0110: begin
        r.w = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -65'sh0_8000_0000_0000_0000);
      end
      4'b0111: r.w = b;
      4'b1000: r.w = a ^ b;
      4'b1001: r.w = 64'($signed(a) >>> sh);
`ifdef ALU_MUL_EN
      4'b1010: r.w = a * b;
`endif
      default: r.w = '0;
    endcase
    r.zncv = {r.w == 64'd0, r.w[63], c, v};
    return r;
  endfunction

  function automatic logic [63:0] randVal();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic rdy);
    InValid  = v;
    ALUCtrl  = op;
    BusA     = a;
    BusB     = b;
    OutReady = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  vecT vecs[$];
  resT q[$];
  resT expStall[3];
  logic [3:0] opList[13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7,
                             4'h8, 4'h9, 4'h5, 4'hB, 4'hF, 4'hA};

  initial begin
    vecs.push_back('{"add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b0101});
    vecs.push_back('{"sub_eq",  4'b0110, 64'd5, 64'd5, 64'd0, 4'b1010});
    vecs.push_back('{"sub_neg", 4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100});
    vecs.push_back('{"asr",     4'b1001, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 4'b0100});
    vecs.push_back('{"lsr",     4'b0100, 64'h8000_0000_0000_0000, 64'h43, 64'h1000_0000_0000_0000, 4'b0000});
    vecs.push_back('{"and",     4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000});
    vecs.push_back('{"or",      4'b0001, 64'hF0F0, 64'h0F0F, 64'hFFFF, 4'b0000});
    vecs.push_back('{"xor",     4'b1000, 64'hFF00, 64'h0FF0, 64'hF0F0, 4'b0000});
    vecs.push_back('{"lsl63",   4'b0011, 64'd1, 64'hFFFF_FFFF_FFFF_FF3F, 64'h8000_0000_0000_0000, 4'b0100});
    vecs.push_back('{"passb",   4'b0111, 64'hDEAD, 64'h1234, 64'h1234, 4'b0000});
    vecs.push_back('{"add_c",   4'b0010, '1, 64'd1, 64'd0, 4'b1010});
    vecs.push_back('{"sub_ovf", 4'b0110, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011});
    vecs.push_back('{"bad5",    4'b0101, 64'd5, 64'd7, 64'd0, 4'b1000});
    vecs.push_back('{"badF",    4'b1111, '1, '1, 64'd0, 4'b1000});

    Reset = 1'b1;
    applyStimulus(0, 4'h0, '0, '0, 0);
    step();
    step();
    Reset = 1'b0;
    #1;
    checkOutput("rst.outValid", 64'(OutValid), 64'd0);
    checkOutput("rst.busW", BusW, 64'd0);
    checkOutput("rst.zncv", 64'({Zero, Negative, Carry, Overflow}), 64'b1000);
    checkOutput("rst.inReady", 64'(InReady), 64'd1);

    // Reset while a result is held and a new operation is offered.
    applyStimulus(1, 4'b0010, 64'd1, 64'd2, 0);
    step();
    checkOutput("rstHold.pre", 64'(OutValid), 64'd1);
    Reset = 1'b1;
    applyStimulus(1, 4'b0010, 64'd5, 64'd6, 1);
    step();
    Reset = 1'b0;
    applyStimulus(0, 4'h0, '0, '0, 0);
    checkOutput("rstHold.outValid", 64'(OutValid), 64'd0);
    checkOutput("rstHold.busW", BusW, 64'd0);
    checkOutput("rstHold.zero", 64'(Zero), 64'd1);
    checkOutput("rstHold.inReady", 64'(InReady), 64'd1);

    foreach (vecs[i]) begin
      applyStimulus(1, vecs[i].op, vecs[i].a, vecs[i].b, 1);
      checkOutput({vecs[i].name, ".inReady"}, 64'(InReady), 64'd1);
      step();
      checkOutput({vecs[i].name, ".valid"}, 64'(OutValid), 64'd1);
      checkOutput({vecs[i].name, ".w"}, BusW, vecs[i].expW);
      checkOutput({vecs[i].name, ".zncv"}, 64'({Zero, Negative, Carry, Overflow}), 64'(vecs[i].expZncv));
    end
    applyStimulus(0, 4'h0, '0, '0, 1);
    step();
    checkOutput("drain.idle", 64'(OutValid), 64'd0);

    // Back-to-back AND/OR/XOR against a stalled consumer.
    begin
      logic [3:0] sOp[3] = '{4'b0000, 4'b0001, 4'b1000};
      int idx = 1;
      int got = 0;
      for (int k = 0; k < 3; k++) expStall[k] = model(sOp[k], 64'hFF00, 64'h0FF0);
      applyStimulus(1, sOp[0], 64'hFF00, 64'h0FF0, 0);
      step();
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1, sOp[1], 64'hFF00, 64'h0FF0, 0);
        checkOutput($sformatf("stall.inReady%0d", k), 64'(InReady), 64'd0);
        checkOutput($sformatf("stall.hold%0d", k), BusW, expStall[0].w);
        step();
      end
      for (int k = 0; k < 10 && got < 3; k++) begin
        if (idx < 3) applyStimulus(1, sOp[idx], 64'hFF00, 64'h0FF0, 1);
        else         applyStimulus(0, 4'h0, '0, '0, 1);
        if (OutValid) begin
          checkOutput($sformatf("stall.res%0d", got), BusW, expStall[got].w);
          got++;
        end
        if (InValid && InReady) idx++;
        step();
      end
      checkOutput("stall.count", 64'(got), 64'd3);
      applyStimulus(0, 4'h0, '0, '0, 1);
      checkOutput("stall.noDup", 64'(OutValid), 64'd0);
    end

`ifdef ALU_MUL_EN
    begin
      int lat = 1;
      int readyHigh = 0;
      int seen = 0;
      applyStimulus(1, 4'b1010, 64'h1_0000_0001, 64'd3, 1);
      checkOutput("mul.accept", 64'(InReady), 64'd1);
      step();
      applyStimulus(0, 4'h0, '0, '0, 1);
      while (!OutValid && lat < 100) begin
        if (InReady) readyHigh++;
        step();
        lat++;
      end
      checkOutput("mul.latency", 64'(lat), 64'd65);
      checkOutput("mul.w", BusW, 64'h3_0000_0003);
      checkOutput("mul.inReadyLow", 64'(readyHigh), 64'd0);
      step();

      applyStimulus(1, 4'b1010, 64'h1_0000_0001, 64'd3, 1);
      step();
      applyStimulus(0, 4'h0, '0, '0, 1);
      for (int k = 1; k < 20; k++) step();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      #1;
      checkOutput("mulRst.inReady", 64'(InReady), 64'd1);
      for (int k = 0; k < 80; k++) begin
        if (OutValid) seen++;
        step();
      end
      checkOutput("mulRst.noResult", 64'(seen), 64'd0);
    end
`else
    applyStimulus(1, 4'b1010, 64'h1_0000_0001, 64'd3, 1);
    step();
    applyStimulus(0, 4'h0, '0, '0, 1);
    checkOutput("mulOff.valid", 64'(OutValid), 64'd1);
    checkOutput("mulOff.w", BusW, 64'd0);
    checkOutput("mulOff.zero", 64'(Zero), 64'd1);
    step();
`endif

    // Randomized traffic with random consumer back-pressure.
    begin
      int issued = 0;
      logic took;
      resT e;
      applyStimulus(0, 4'h0, '0, '0, 1);
      for (int cyc = 0; cyc < 8000 && (issued < 200 || q.size() > 0); cyc++) begin
        if (!InValid && issued < 200 && $urandom_range(0, 3) != 0) begin
          ALUCtrl = opList[$urandom_range(0, 12)];
          if (ALUCtrl == 4'hA && $urandom_range(0, 3) != 0) ALUCtrl = 4'h2;
          BusA    = randVal();
          BusB    = randVal();
          InValid = 1'b1;
        end
        OutReady = ($urandom_range(0, 2) != 0);
        #1;
        if (OutValid && OutReady) begin
          if (q.size() == 0) begin
            checkOutput("rand.spurious", 64'(OutValid), 64'd0);
          end else begin
            e = q.pop_front();
            checkOutput("rand.w", BusW, e.w);
            checkOutput("rand.zncv", 64'({Zero, Negative, Carry, Overflow}), 64'(e.zncv));
          end
        end
        took = InValid && InReady;
        if (took) begin
          q.push_back(model(ALUCtrl, BusA, BusB));
          issued++;
        end
        step();
        if (took) InValid = 1'b0;
      end
      checkOutput("rand.issued", 64'(issued), 64'd200);
      checkOutput("rand.pending", 64'(q.size()), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
